ucie_ctl_csr_adapter_arb: RTL and testbench
===========================================

Name: ucie_ctl_csr_adapter_arb

Overview:
Arbiter and sequencer for the single adapter-side write port of the UCIe controller CSR block (A_Valid/A_addr/A_WDATA). It shares that port among NUM_REQ adapter requesters, such as the retrain FSM, error logger and link-status updater, using round-robin arbitration. It snoops the APB protocol-side setup phase and defers any adapter write that targets the same register in the same cycle, so a protocol write is never silently overwritten. The block sits between the adapter-layer requesters and the CSR.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 8, CSR byte-address width
DATA_W, 32, register data width
HOLD_MAX, 4, max consecutive collision-stall cycles before a forced issue (1..15)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_req_valid  in  NUM_REQ  per-requester write request
i_req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester k at [k*ADDR_W +: ADDR_W]
i_req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing
o_req_ready  out  NUM_REQ  one-hot accept strobe
i_P_Select  in  1  APB select (snoop)
i_P_Enable  in  1  APB enable (snoop)
i_P_WR  in  1  APB write=1 (snoop)
i_P_addr  in  ADDR_W  APB address (snoop)
o_A_Valid  out  1  adapter write strobe to CSR
o_A_addr  out  ADDR_W  adapter write address
o_A_WDATA  out  DATA_W  adapter write data
o_grant_id  out  3  index of latched winner
o_busy  out  1  1 while in ISSUE
o_hold_timeout  out  1  forced-issue indicator

Behaviour:
- Clock and reset: reset i_rst_n, asynchronous, active-low; clock i_clk.
- Reset values: state=IDLE, rr_ptr=0, hold_cnt=0, o_A_addr=0, o_A_WDATA=0, o_grant_id=0. Combinational outputs o_A_Valid, o_req_ready, o_busy and o_hold_timeout evaluate to 0 in IDLE.
- Collision, defined combinationally: p_wr_setup = i_P_Select & ~i_P_Enable & i_P_WR; collide = p_wr_setup & (i_P_addr == o_A_addr).
- IDLE:
  - If any i_req_valid is set, pick the first valid index searching upward from rr_ptr, with wrap-around.
  - At the clock edge, latch the winner's addr into o_A_addr, its data into o_A_WDATA and its index into o_grant_id; clear hold_cnt; go to ISSUE.
  - If no request is valid, stay in IDLE.
- ISSUE (o_busy=1):
  - If collide=0, or hold_cnt == HOLD_MAX: o_A_Valid=1, o_req_ready[o_grant_id]=1, o_hold_timeout=(collide & hold_cnt==HOLD_MAX). Next state is IDLE, rr_ptr <= (o_grant_id+1) mod NUM_REQ.
  - Otherwise: o_A_Valid=0, hold_cnt++, stay in ISSUE. No re-arbitration; the latched winner is kept.
- Latency: a request valid in cycle N, with the arbiter idle and no collision, produces o_A_Valid and ready in cycle N+1. Peak throughput is one write per 2 cycles.
- Requester protocol:
  - Hold valid, addr and data stable until ready is seen; drop valid, or present the next request, in the cycle after ready.
  - Dropping valid while granted is a protocol violation. The latched write still issues.
- Only one requester can be granted at a time, so o_req_ready is always one-hot or zero. o_A_Valid equals OR(o_req_ready).
- A protocol write to a different address in the same cycle does not stall the adapter write. APB reads never stall it.
- NUM_REQ=1 degenerates to a pass-through with a 1-cycle latch and collision stall.
- Asynchronous reset during ISSUE aborts the pending write. No o_A_Valid is emitted; the requester must re-request after reset.

Test Plan:
- Single request: req0 valid with addr 0x14, data 0x0002_0000 at cycle 0, no APB activity -> cycle 1: o_A_Valid=1, o_A_addr=0x14, o_A_WDATA=0x0002_0000, o_req_ready=0001; cycle 2: o_busy=0.
- Round-robin: all 4 requests held valid continuously -> grants in order 0,1,2,3,0 on cycles 1,3,5,7,9; each o_A_Valid carries the matching requester's addr/data.
- Collision defer: req1 targets 0x10; APB setup-phase write to 0x10 during cycle 1 only -> o_A_Valid=0 in cycle 1, o_A_Valid=1 and ready=0010 in cycle 2.
- Timeout: HOLD_MAX=4; APB write-setup to 0x24 held every cycle while req2 targets 0x24 -> 4 stall cycles, then o_A_Valid=1 with o_hold_timeout=1 in cycle 5.
- Non-colliding traffic: APB write to 0x28 and APB read of 0x24 while req3 writes 0x24 -> no stall; o_A_Valid in cycle 1.
- Reset mid-op: assert i_rst_n=0 while in ISSUE -> all outputs 0 immediately, rr_ptr=0; after release, a req2-only request is granted 1 cycle later with o_grant_id=2.

Source files
------------

// File: rtl/ucie_ctl_csr_adapter_arb.sv
// Round-robin arbiter for the CSR adapter-side write port. It defers a write that
// would land on the same register as an APB write setup phase in the same cycle.
module ucie_ctl_csr_adapter_arb #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int HOLD_MAX = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic                      i_P_Select,
  input  logic                      i_P_Enable,
  input  logic                      i_P_WR,
  input  logic [ADDR_W-1:0]         i_P_addr,
  output logic                      o_A_Valid,
  output logic [ADDR_W-1:0]         o_A_addr,
  output logic [DATA_W-1:0]         o_A_WDATA,
  output logic [2:0]                o_grant_id,
  output logic                      o_busy,
  output logic                      o_hold_timeout
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t state, state_nxt;
  logic [2:0] rr_ptr;
  logic [3:0] hold_cnt;

  logic p_wr_setup, collide, hold_expired, fire;
  logic any_valid;
  logic [2*NUM_REQ-1:0] dbl_valid;
  logic [NUM_REQ-1:0] rot_valid;
  logic [2:0] offset, pick;
  logic [3:0] pick_sum;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  assign p_wr_setup   = i_P_Select & ~i_P_Enable & i_P_WR;
  assign collide      = p_wr_setup & (i_P_addr == o_A_addr);
  assign hold_expired = (hold_cnt == 4'(HOLD_MAX));

  // Rotate the request vector so bit 0 is rr_ptr; the lowest set bit is the winner.
  always_comb begin
    dbl_valid = {i_req_valid, i_req_valid};
    rot_valid = NUM_REQ'(dbl_valid >> rr_ptr);
    any_valid = 1'b0;
    offset    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_valid[i]) begin
        any_valid = 1'b1;
        offset    = 3'(i);
      end
    end
    pick_sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (pick_sum >= 4'(NUM_REQ)) pick_sum = pick_sum - 4'(NUM_REQ);
    pick = pick_sum[2:0];
  end

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick == 3'(k)) begin
        win_addr = i_req_addr[k*ADDR_W +: ADDR_W];
        win_data = i_req_wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = ISSUE;
      ISSUE:   if (fire)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic; o_busy is the externally visible state bit
  always_comb begin
    o_busy         = (state == ISSUE);
    fire           = o_busy & (~collide | hold_expired);
    o_A_Valid      = fire;
    o_hold_timeout = o_busy & collide & hold_expired;
    o_req_ready    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      o_req_ready[k] = fire & (o_grant_id == 3'(k));
    end
  end

  // Latched winner, stall counter and round-robin pointer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr     <= '0;
      hold_cnt   <= '0;
      o_A_addr   <= '0;
      o_A_WDATA  <= '0;
      o_grant_id <= '0;
    end else if (state == IDLE) begin
      if (any_valid) begin
        o_A_addr   <= win_addr;
        o_A_WDATA  <= win_data;
        o_grant_id <= pick;
        hold_cnt   <= '0;
      end
    end else if (fire) begin
      rr_ptr <= (o_grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : o_grant_id + 3'd1;
    end else begin
      hold_cnt <= hold_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_ucie_ctl_csr_adapter_arb.sv
// Bench for the CSR adapter-port arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model and a write scoreboard.
module tb_ucie_ctl_csr_adapter_arb;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int HM = 4;
  localparam int SW = 3 + AW + DW;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic psel, pen, pwr;
  logic [AW-1:0] paddr;
  logic a_valid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic [2:0] grant_id;
  logic busy, hold_to;

  int checks = 0;
  int failures = 0;
  logic [SW-1:0] exp_q[$];

  // Behavioural model state
  bit m_busy;
  int m_id, m_hold, m_ptr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit e_valid, e_to;
  logic [N-1:0] e_ready;

  ucie_ctl_csr_adapter_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .HOLD_MAX(HM)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_req_ready(req_ready),
    .i_P_Select(psel), .i_P_Enable(pen), .i_P_WR(pwr), .i_P_addr(paddr),
    .o_A_Valid(a_valid), .o_A_addr(a_addr), .o_A_WDATA(a_wdata),
    .o_grant_id(grant_id), .o_busy(busy), .o_hold_timeout(hold_to)
  );

  // Clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drivers
  task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[k] = 1'b1;
    req_addr[k*AW +: AW] = a;
    req_wdata[k*DW +: DW] = d;
  endtask

  task automatic clr_req(input int k);
    req_valid[k] = 1'b0;
  endtask

  task automatic apb(input logic s, input logic e, input logic w, input logic [AW-1:0] a);
    psel = s; pen = e; pwr = w; paddr = a;
  endtask

  // Reference model: a write is deferred only while an APB write setup targets the
  // latched address, and then for at most HM cycles.
  task automatic model_reset();
    m_busy = 0; m_id = 0; m_hold = 0; m_ptr = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic model_eval();
    bit coll;
    coll = psel && !pen && pwr && (paddr == m_addr);
    e_valid = m_busy && (!coll || m_hold == HM);
    e_to = e_valid && coll;
    e_ready = e_valid ? (N'(1) << m_id) : '0;
  endtask

  task automatic model_commit();
    bit found;
    int k;
    if (!rst_n) begin
      model_reset();
    end else begin
      model_eval();
      if (!m_busy) begin
        found = 0;
        for (int i = 0; i < N; i++) begin
          k = (m_ptr + i) % N;
          if (!found && req_valid[k]) begin
            found = 1; m_id = k; m_hold = 0; m_busy = 1;
            m_addr = req_addr[k*AW +: AW];
            m_data = req_wdata[k*DW +: DW];
          end
        end
      end else if (e_valid) begin
        m_busy = 0;
        m_ptr = (m_id + 1) % N;
      end else begin
        m_hold++;
      end
    end
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; req_addr = '0; req_wdata = '0;
    apb(0, 0, 0, '0);
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(); #2;
    checks++; if (a_addr !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", a_addr); end
    checks++; if (a_wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", a_wdata); end
    checks++; if (grant_id !== 3'd0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
    checks++; if ({a_valid, busy, hold_to, req_ready} !== 7'b0) begin failures++; $display("FAIL reset_outputs got=%b exp=0", {a_valid, busy, hold_to, req_ready}); end
    tick(); tick(); #2;
    checks++; if ({a_valid, busy} !== 2'b00) begin failures++; $display("FAIL idle_no_req got=%b exp=00", {a_valid, busy}); end
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 8'h14, 32'h0002_0000); #2;
    checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL single_c0_valid got=%b exp=0", a_valid); end
    tick(); #2;
    checks++; if ({a_valid, busy, hold_to} !== 3'b110) begin failures++; $display("FAIL single_c1_flags got=%b exp=110", {a_valid, busy, hold_to}); end
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_c1_ready got=%b exp=0001", req_ready); end
    checks++; if (a_addr !== 8'h14 || a_wdata !== 32'h0002_0000) begin failures++; $display("FAIL single_c1_payload got=%h/%h exp=14/00020000", a_addr, a_wdata); end
    tick(); clr_req(0); #2;
    checks++; if ({a_valid, busy} !== 2'b00) begin failures++; $display("FAIL single_c2_idle got=%b exp=00", {a_valid, busy}); end
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, AW'(8'h40 + k * 4), DW'(32'hA000_0000 + k));
    #2;
    for (int c = 1; c <= 9; c++) begin
      tick(); #2;
      if (c % 2 == 1) begin
        g = ((c - 1) / 2) % N;
        checks++; if (a_valid !== 1'b1 || grant_id !== 3'(g)) begin failures++; $display("FAIL rr_grant c=%0d got=%b/%0d exp=1/%0d", c, a_valid, grant_id, g); end
        checks++; if (req_ready !== (N'(1) << g)) begin failures++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, N'(1) << g); end
        checks++; if (a_addr !== AW'(8'h40 + g * 4) || a_wdata !== DW'(32'hA000_0000 + g)) begin failures++; $display("FAIL rr_payload c=%0d got=%h/%h", c, a_addr, a_wdata); end
      end else begin
        checks++; if ({a_valid, busy} !== 2'b00) begin failures++; $display("FAIL rr_gap c=%0d got=%b exp=00", c, {a_valid, busy}); end
      end
    end
    req_valid = '0;
  endtask

  task automatic test_collision();
    do_reset();
    set_req(1, 8'h10, 32'h1111_0010); #2;
    tick(); apb(1, 0, 1, 8'h10); #2;
    checks++; if ({a_valid, busy, req_ready} !== 6'b010000) begin failures++; $display("FAIL coll_stall got=%b exp=010000", {a_valid, busy, req_ready}); end
    tick(); apb(0, 0, 0, '0); #2;
    checks++; if ({a_valid, hold_to, req_ready} !== 6'b100010) begin failures++; $display("FAIL coll_issue got=%b exp=100010", {a_valid, hold_to, req_ready}); end
    tick(); clr_req(1);
  endtask

  task automatic test_timeout();
    do_reset();
    set_req(2, 8'h24, 32'h2222_0024); apb(1, 0, 1, 8'h24); #2;
    for (int c = 1; c <= HM; c++) begin
      tick(); #2;
      checks++; if ({a_valid, busy, hold_to} !== 3'b010) begin failures++; $display("FAIL to_stall c=%0d got=%b exp=010", c, {a_valid, busy, hold_to}); end
    end
    tick(); #2;
    checks++; if ({a_valid, hold_to, req_ready} !== 6'b110100) begin failures++; $display("FAIL to_forced got=%b exp=110100", {a_valid, hold_to, req_ready}); end
    tick(); clr_req(2); apb(0, 0, 0, '0);
  endtask

  task automatic test_no_collision();
    do_reset();
    set_req(3, 8'h24, 32'h3333_0001); #2;
    tick(); apb(1, 0, 1, 8'h28); #2;
    checks++; if ({a_valid, req_ready} !== 5'b11000) begin failures++; $display("FAIL nc_other_addr got=%b exp=11000", {a_valid, req_ready}); end
    tick(); set_req(3, 8'h24, 32'h3333_0002); apb(0, 0, 0, '0); #2;
    tick(); apb(1, 0, 0, 8'h24); #2;
    checks++; if (a_valid !== 1'b1 || a_wdata !== 32'h3333_0002) begin failures++; $display("FAIL nc_read got=%b/%h exp=1/33330002", a_valid, a_wdata); end
    tick(); set_req(3, 8'h24, 32'h3333_0003); apb(0, 0, 0, '0); #2;
    tick(); apb(1, 1, 1, 8'h24); #2;
    checks++; if (a_valid !== 1'b1 || a_wdata !== 32'h3333_0003) begin failures++; $display("FAIL nc_access_phase got=%b/%h exp=1/33330003", a_valid, a_wdata); end
    tick(); clr_req(3); apb(0, 0, 0, '0);
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    set_req(1, 8'h30, 32'h5555_0001); #2;
    tick(); #2;
    rst_n = 1'b0; #1;
    checks++; if ({a_valid, busy, hold_to, req_ready} !== 7'b0 || a_addr !== '0 || a_wdata !== '0 || grant_id !== 3'd0) begin failures++; $display("FAIL rst_mid_outputs got=%b %h %h %0d exp=0", {a_valid, busy, hold_to, req_ready}, a_addr, a_wdata, grant_id); end
    clr_req(1); set_req(2, 8'h34, 32'h5555_0002); model_reset();
    @(negedge clk); rst_n = 1'b1; #2;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_release_idle got=%b exp=0", busy); end
    tick(); #2;
    checks++; if (a_valid !== 1'b1 || grant_id !== 3'd2 || a_addr !== 8'h34) begin failures++; $display("FAIL rst_regrant got=%b/%0d/%h exp=1/2/34", a_valid, grant_id, a_addr); end
    // Pointer now 3; abort a write from requester 3, then show the pointer restarted at 0.
    tick(); clr_req(2); set_req(3, 8'h38, 32'h5555_0003); #2;
    tick(); #2;
    rst_n = 1'b0; #1;
    checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL rst_mid2_valid got=%b exp=0", a_valid); end
    set_req(2, 8'h3C, 32'h5555_0004); model_reset();
    @(negedge clk); rst_n = 1'b1; #2;
    tick(); #2;
    checks++; if (grant_id !== 3'd2 || a_valid !== 1'b1) begin failures++; $display("FAIL rst_ptr_cleared got=%0d/%b exp=2/1", grant_id, a_valid); end
    tick(); req_valid = '0;
  endtask

  task automatic test_random();
    logic [AW-1:0] tbl[4];
    bit pend[N];
    logic [N-1:0] ack;
    int storm;
    logic [AW-1:0] saddr;
    logic [SW-1:0] got, exp;
    tbl[0] = 8'h10; tbl[1] = 8'h14; tbl[2] = 8'h24; tbl[3] = 8'h28;
    do_reset();
    for (int k = 0; k < N; k++) pend[k] = 0;
    ack = '0; storm = 0; saddr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (ack[k]) pend[k] = 0;
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1;
          set_req(k, tbl[$urandom_range(0, 3)], $urandom);
        end else if (!pend[k]) begin
          clr_req(k);
        end
      end
      if (storm == 0 && $urandom_range(0, 11) == 0) begin
        storm = $urandom_range(1, 7);
        saddr = tbl[$urandom_range(0, 3)];
      end
      if (storm > 0) begin
        apb(1, 0, 1, saddr);
        storm--;
      end else begin
        apb(1'($urandom), 1'($urandom), 1'($urandom), tbl[$urandom_range(0, 3)]);
      end
      #2;
      model_eval();
      checks++; if (a_valid !== e_valid || busy !== m_busy) begin failures++; $display("FAIL rnd_valid_busy cyc=%0d got=%b%b exp=%b%b", cyc, a_valid, busy, e_valid, m_busy); end
      checks++; if (req_ready !== e_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); end
      checks++; if (hold_to !== e_to) begin failures++; $display("FAIL rnd_timeout cyc=%0d got=%b exp=%b", cyc, hold_to, e_to); end
      if (e_valid) exp_q.push_back({3'(m_id), m_addr, m_data});
      if (a_valid === 1'b1) begin
        got = {grant_id, a_addr, a_wdata};
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rnd_unexpected_write cyc=%0d got=%h exp=none", cyc, got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin failures++; $display("FAIL rnd_write cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
      end
      ack = e_ready;
      tick();
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_collision();
    test_timeout();
    test_no_collision();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
